// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and
// the default widths/depth used by the interface and the top level.
package fifo_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LEN_WIDTH  = 16;
    localparam int DEFAULT_BUF_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Bundle of the command, FIFO-pull and downstream stream signals of the
// burst reader. The reader side uses the master modport; whatever drives
// commands, models the FIFO and consumes the stream uses the slave modport.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = fifo_reader_pkg::DEFAULT_DATA_WIDTH,
    parameter int LEN_WIDTH  = fifo_reader_pkg::DEFAULT_LEN_WIDTH
);

    logic [LEN_WIDTH-1:0]  cmd_len_i;
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  fifo_req_o;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_valid_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  data_o_valid;
    logic                  data_o_ready;
    logic                  data_o_last;
    logic                  done_o;
    logic                  err_o;

    modport master (
        input  cmd_len_i, cmd_valid_i, fifo_data_i, fifo_valid_i, data_o_ready,
        output cmd_ready_o, fifo_req_o, data_o, data_o_valid, data_o_last,
               done_o, err_o
    );

    modport slave (
        output cmd_len_i, cmd_valid_i, fifo_data_i, fifo_valid_i, data_o_ready,
        input  cmd_ready_o, fifo_req_o, data_o, data_o_valid, data_o_last,
               done_o, err_o
    );

endinterface

// File: rtl/reader_skid_buf.sv
// Small circular skid buffer that absorbs words returning from the FIFO.
// The head entry is always visible so the stream output holds steady while
// the consumer stalls. The caller never pushes when full or pops when empty.
module reader_skid_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset_i,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      pop,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [DATA_WIDTH-1:0]     head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [OCC_W-1:0]      count;

    // Storage array: write the incoming word at the tail slot.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[tail] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
        end
    end

    // Occupancy tracks push/pop; a simultaneous push and pop cancel out.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign occupancy = count;
    assign head_data = mem[head];

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: accepts a word-count command, pulls exactly that many words
// from a one-cycle-latency FIFO without ever overrunning its skid buffer,
// and streams them downstream with a last marker and a completion pulse.
module fifo_burst_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH,
    parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
    input  logic                clk,
    input  logic                reset_i,
    fifo_burst_reader_if.master bus
);

    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(BUF_DEPTH);

    reader_state_t state;
    reader_state_t state_next;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  received;
    logic [LEN_WIDTH-1:0]  sent;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  last_index;
    logic [OCC_W-1:0]      occupancy;
    logic [OCC_W-1:0]      free;
    logic [DATA_WIDTH-1:0] head_data;
    logic req_q;
    logic err_q;
    logic in_fetch;
    logic full;
    logic push;
    logic pop;
    logic data_valid;
    logic fifo_req;
    logic accept;
    logic fetch_complete;
    logic cmd_ready;
    logic done;

    // The request rule counts the possibly-in-flight request (req_q) against
    // both the words still owed and the free buffer slots, so a grant can
    // never over-fetch or overflow even though it is only seen a cycle later.
    assign in_fetch       = (state == FETCH);
    assign remaining      = len_q - received;
    assign free           = DEPTH_L - occupancy;
    assign full           = (occupancy == DEPTH_L);
    assign fifo_req       = in_fetch && (remaining > LEN_WIDTH'(req_q))
                                     && (free > OCC_W'(req_q));
    assign push           = bus.fifo_valid_i && in_fetch && !full;
    assign data_valid     = (occupancy != '0);
    assign pop            = data_valid && bus.data_o_ready;
    assign last_index     = len_q - LEN_WIDTH'(1);
    assign accept         = cmd_ready && bus.cmd_valid_i;
    assign fetch_complete = ((received + LEN_WIDTH'(bus.fifo_valid_i)) == len_q);

    reader_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset_i   (reset_i),
        .push      (push),
        .push_data (bus.fifo_data_i),
        .pop       (pop),
        .occupancy (occupancy),
        .head_data (head_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid_i) begin
                    state_next = (bus.cmd_len_i == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (fetch_complete) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (sent == last_index)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst length and progress counters, cleared on every accepted command.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            len_q    <= '0;
            received <= '0;
            sent     <= '0;
        end else if (accept) begin
            len_q    <= bus.cmd_len_i;
            received <= '0;
            sent     <= '0;
        end else begin
            if (in_fetch && bus.fifo_valid_i) begin
                received <= received + LEN_WIDTH'(1);
            end
            if (pop) begin
                sent <= sent + LEN_WIDTH'(1);
            end
        end
    end

    // Remember last cycle's request and latch protocol errors until reset.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            req_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            req_q <= fifo_req;
            if (bus.fifo_valid_i && (!in_fetch || full)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.fifo_req_o   = fifo_req;
    assign bus.data_o       = head_data;
    assign bus.data_o_valid = data_valid;
    assign bus.data_o_last  = data_valid && (sent == last_index);
    assign bus.done_o       = done;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader. A queue models the pull FIFO
// (one-cycle grant latency, requests ignored while empty); expected output
// for a burst is simply the first len words of that queue, in order.
module tb_fifo_burst_reader;

    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_i = 1'b1;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] out_data[$];
    bit            out_last[$];
    int            out_cycle[$];
    int            accept_cycles[$];
    int            done_cycles[$];
    int            req_cycles[$];
    int  grants    = 0;
    int  push_cnt  = 0;
    int  pop_cnt   = 0;
    int  level     = 0;
    int  max_level = 0;
    int  hold_viol = 0;
    bit  req_pending  = 1'b0;
    bit  force_word   = 1'b0;
    bit  random_ready = 1'b0;
    int  checks = 0;
    int  errors = 0;

    // Observer: samples everything mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_i) begin
                req_pending = 1'b0;
                push_cnt    = 0;
                pop_cnt     = 0;
            end else begin
                level = push_cnt - pop_cnt;
                if (level > max_level) max_level = level;
                if (level >= DEPTH && bus.fifo_req_o) hold_viol++;
                req_pending = bus.fifo_req_o;
                if (bus.fifo_req_o) req_cycles.push_back(cycle);
                if (bus.fifo_valid_i) push_cnt++;
                if (bus.cmd_valid_i && bus.cmd_ready_o) accept_cycles.push_back(cycle);
                if (bus.data_o_valid && bus.data_o_ready) begin
                    out_data.push_back(bus.data_o);
                    out_last.push_back(bus.data_o_last);
                    out_cycle.push_back(cycle);
                    pop_cnt++;
                end
                if (bus.done_o) done_cycles.push_back(cycle);
            end
        end
    end

    // FIFO model and optional random downstream ready, driven just after the edge.
    initial begin
        bus.fifo_valid_i = 1'b0;
        bus.fifo_data_i  = '0;
        bus.data_o_ready = 1'b0;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_len_i    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset_i) begin
                bus.fifo_valid_i = 1'b0;
            end else if (force_word) begin
                bus.fifo_valid_i = 1'b1;
                bus.fifo_data_i  = $urandom;
                force_word       = 1'b0;
            end else if (req_pending && fifo_q.size() > 0) begin
                bus.fifo_valid_i = 1'b1;
                bus.fifo_data_i  = fifo_q.pop_front();
                grants++;
            end else begin
                bus.fifo_valid_i = 1'b0;
            end
            if (random_ready) bus.data_o_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic clear_log;
        out_data.delete();
        out_last.delete();
        out_cycle.delete();
        accept_cycles.delete();
        done_cycles.delete();
        req_cycles.delete();
        grants    = 0;
        max_level = 0;
        hold_viol = 0;
    endtask

    task automatic send_cmd(input logic [LW-1:0] len);
        int n = accept_cycles.size();
        @(posedge clk);
        #1;
        bus.cmd_len_i   = len;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 60 && accept_cycles.size() == n; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (accept_cycles.size() == n) begin
            errors++;
            $display("FAIL cmd_accept: command len=%0d not accepted within 60 cycles", len);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int i = 0; i < budget && done_cycles.size() < target; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (done_cycles.size() < target) begin
            errors++;
            $display("FAIL %s_done: saw %0d done pulses, required %0d", name, done_cycles.size(), target);
        end
    endtask

    task automatic test_reset;
        @(posedge clk);
        #3;
        checks++;
        if ({bus.cmd_ready_o, bus.fifo_req_o, bus.data_o_valid, bus.data_o_last,
             bus.done_o, bus.err_o} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 100000", {bus.cmd_ready_o, bus.fifo_req_o,
                     bus.data_o_valid, bus.data_o_last, bus.done_o, bus.err_o});
        end
        checks++;
        if (bus.data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", bus.data_o);
        end
        @(negedge clk);
        #2;
        reset_i = 1'b0;
    endtask

    task automatic test_latency_basic;
        logic [DW-1:0] exp[$];
        int a;
        clear_log();
        for (int i = 0; i < 4; i++) exp.push_back($urandom);
        fifo_q = exp;
        bus.data_o_ready = 1'b1;
        send_cmd(16'd4);
        wait_done(1, 40, "t1");
        a = (accept_cycles.size() > 0) ? accept_cycles[0] : 0;
        checks++;
        if (out_data.size() != 4) begin
            errors++;
            $display("FAIL t1_count: got %0d words required 4", out_data.size());
        end
        for (int i = 0; i < 4 && i < out_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp[i] || out_last[i] !== (i == 3) || out_cycle[i] != a + 3 + i) begin
                errors++;
                $display("FAIL t1_word[%0d]: got %h last=%0d cycle=%0d required %h last=%0d cycle=%0d",
                         i, out_data[i], out_last[i], out_cycle[i], exp[i], (i == 3), a + 3 + i);
            end
        end
        checks++;
        if (req_cycles.size() == 0 || req_cycles[0] != a + 1) begin
            errors++;
            $display("FAIL t1_first_req: got %0d requests, first at rel %0d, required rel 1",
                     req_cycles.size(), (req_cycles.size() > 0) ? req_cycles[0] - a : -1);
        end
        checks++;
        if (done_cycles.size() == 0 || done_cycles[0] != a + 7) begin
            errors++;
            $display("FAIL t1_done_cycle: got rel %0d required rel 7",
                     (done_cycles.size() > 0) ? done_cycles[0] - a : -1);
        end
        checks++;
        if (grants != 4 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL t1_grants: got %0d grants, %0d left required 4 grants, 0 left", grants, fifo_q.size());
        end
    endtask

    task automatic test_zero_len;
        int a;
        clear_log();
        send_cmd(16'd0);
        wait_done(1, 10, "t2");
        a = (accept_cycles.size() > 0) ? accept_cycles[0] : 0;
        checks++;
        if (done_cycles.size() == 0 || done_cycles[0] != a + 1) begin
            errors++;
            $display("FAIL t2_done_cycle: got rel %0d required rel 1",
                     (done_cycles.size() > 0) ? done_cycles[0] - a : -1);
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL t2_after_done: got ready=%b done=%b required ready=1 done=0", bus.cmd_ready_o, bus.done_o);
        end
        checks++;
        if (req_cycles.size() != 0) begin
            errors++;
            $display("FAIL t2_no_req: got %0d requests required 0", req_cycles.size());
        end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] exp[$];
        int g;
        clear_log();
        for (int i = 0; i < 8; i++) exp.push_back($urandom);
        fifo_q = exp;
        bus.data_o_ready = 1'b0;
        send_cmd(16'd8);
        repeat (10) @(negedge clk);
        g = grants;
        @(posedge clk);
        #1;
        bus.data_o_ready = 1'b1;
        wait_done(1, 80, "t3");
        checks++;
        if (g > DEPTH || max_level != DEPTH) begin
            errors++;
            $display("FAIL t3_stall_fill: got %0d grants, peak %0d required <=%0d grants, peak %0d", g, max_level, DEPTH, DEPTH);
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL t3_req_when_full: got %0d requests while full required 0", hold_viol);
        end
        checks++;
        if (out_data.size() != 8 || grants != 8) begin
            errors++;
            $display("FAIL t3_count: got %0d words %0d grants required 8 and 8", out_data.size(), grants);
        end
        for (int i = 0; i < 8 && i < out_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp[i] || out_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL t3_word[%0d]: got %h last=%0d required %h last=%0d", i, out_data[i], out_last[i], exp[i], (i == 7));
            end
        end
    endtask

    task automatic test_starved;
        logic [DW-1:0] b[$];
        clear_log();
        random_ready = 1'b1;
        send_cmd(16'd3);
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) b.push_back($urandom);
        for (int i = 0; i < 6; i++) fifo_q.push_back(b[i]);
        wait_done(1, 80, "t4");
        random_ready = 1'b0;
        bus.data_o_ready = 1'b1;
        checks++;
        if (out_data.size() != 3 || grants != 3) begin
            errors++;
            $display("FAIL t4_count: got %0d words %0d grants required 3 and 3", out_data.size(), grants);
        end
        for (int i = 0; i < 3 && i < out_data.size(); i++) begin
            checks++;
            if (out_data[i] !== b[i] || out_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL t4_word[%0d]: got %h last=%0d required %h last=%0d", i, out_data[i], out_last[i], b[i], (i == 2));
            end
        end
        checks++;
        if (fifo_q.size() != 3 || (fifo_q.size() == 3 && (fifo_q[0] !== b[3] || fifo_q[2] !== b[5]))) begin
            errors++;
            $display("FAIL t4_leftover: got %0d words left in FIFO required B3..B5", fifo_q.size());
        end
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL t4_err: got %b required 0", bus.err_o);
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [DW-1:0] c0;
        clear_log();
        for (int i = 0; i < 6; i++) fifo_q.push_back($urandom);
        bus.data_o_ready = 1'b1;
        send_cmd(16'd6);
        for (int i = 0; i < 30 && out_data.size() < 2; i++) @(negedge clk);
        checks++;
        if (out_data.size() < 2) begin
            errors++;
            $display("FAIL t5_progress: got %0d words required 2 before reset", out_data.size());
        end
        @(posedge clk);
        #3;
        reset_i = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready_o, bus.fifo_req_o, bus.data_o_valid, bus.data_o_last,
             bus.done_o, bus.err_o} !== 6'b100000 || bus.data_o !== '0) begin
            errors++;
            $display("FAIL t5_in_reset: got ctrl=%b data=%h required 100000 and 0", {bus.cmd_ready_o,
                     bus.fifo_req_o, bus.data_o_valid, bus.data_o_last, bus.done_o, bus.err_o}, bus.data_o);
        end
        @(posedge clk);
        @(negedge clk);
        #2;
        reset_i = 1'b0;
        fifo_q.delete();
        clear_log();
        c0 = $urandom;
        fifo_q.push_back(c0);
        send_cmd(16'd1);
        wait_done(1, 20, "t5");
        checks++;
        if (out_data.size() != 1 || out_data[0] !== c0 || out_last[0] !== 1'b1 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL t5_after_reset: got %0d words first=%h err=%b required 1 word %h last=1 err=0",
                     out_data.size(), (out_data.size() > 0) ? out_data[0] : '0, bus.err_o, c0);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp[$];
        clear_log();
        for (int i = 0; i < 5; i++) exp.push_back($urandom);
        fifo_q = exp;
        bus.data_o_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_len_i   = 16'd2;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 20 && accept_cycles.size() < 1; i++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.cmd_len_i = 16'd3;
        for (int i = 0; i < 60 && accept_cycles.size() < 2; i++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        wait_done(2, 60, "t6");
        checks++;
        if (accept_cycles.size() != 2 || done_cycles.size() != 2 ||
            (accept_cycles.size() == 2 && done_cycles.size() > 0 && accept_cycles[1] != done_cycles[0] + 1)) begin
            errors++;
            $display("FAIL t6_handover: got %0d accepts %0d dones, second accept rel done %0d required 2, 2, 1",
                     accept_cycles.size(), done_cycles.size(),
                     (accept_cycles.size() > 1 && done_cycles.size() > 0) ? accept_cycles[1] - done_cycles[0] : -1);
        end
        checks++;
        if (out_data.size() != 5 || grants != 5) begin
            errors++;
            $display("FAIL t6_count: got %0d words %0d grants required 5 and 5", out_data.size(), grants);
        end
        for (int i = 0; i < 5 && i < out_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp[i] || out_last[i] !== (i == 1 || i == 4)) begin
                errors++;
                $display("FAIL t6_word[%0d]: got %h last=%0d required %h last=%0d", i, out_data[i], out_last[i], exp[i], (i == 1 || i == 4));
            end
        end
    endtask

    task automatic test_random_bursts;
        logic [DW-1:0] exp[$];
        int len;
        int extra;
        for (int t = 0; t < 5; t++) begin
            clear_log();
            exp.delete();
            fifo_q.delete();
            len   = $urandom_range(1, 12);
            extra = $urandom_range(0, 3);
            for (int i = 0; i < len + extra; i++) exp.push_back($urandom);
            fifo_q = exp;
            random_ready = 1'b1;
            send_cmd(LW'(len));
            wait_done(1, 200, "rand");
            random_ready = 1'b0;
            bus.data_o_ready = 1'b1;
            checks++;
            if (out_data.size() != len || fifo_q.size() != extra || hold_viol != 0 || max_level > DEPTH) begin
                errors++;
                $display("FAIL rand_burst%0d: got %0d words %0d left viol=%0d peak=%0d required %0d words %0d left viol=0 peak<=%0d",
                         t, out_data.size(), fifo_q.size(), hold_viol, max_level, len, extra, DEPTH);
            end
            for (int i = 0; i < len && i < out_data.size(); i++) begin
                checks++;
                if (out_data[i] !== exp[i] || out_last[i] !== (i == len - 1)) begin
                    errors++;
                    $display("FAIL rand_word%0d[%0d]: got %h last=%0d required %h last=%0d",
                             t, i, out_data[i], out_last[i], exp[i], (i == len - 1));
                end
            end
        end
        fifo_q.delete();
    endtask

    task automatic test_error;
        clear_log();
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL t7_err_before: got %b required 0", bus.err_o);
        end
        @(negedge clk);
        force_word = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.err_o !== 1'b1 || out_data.size() != 0) begin
            errors++;
            $display("FAIL t7_err_set: got err=%b words=%0d required err=1 words=0", bus.err_o, out_data.size());
        end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.err_o !== 1'b1) begin
            errors++;
            $display("FAIL t7_err_sticky: got %b required 1", bus.err_o);
        end
        @(posedge clk);
        #3;
        reset_i = 1'b1;
        #1;
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL t7_err_reset: got %b required 0", bus.err_o);
        end
        @(negedge clk);
        #2;
        reset_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency_basic();
        test_zero_len();
        test_backpressure();
        test_starved();
        test_reset_mid_burst();
        test_back_to_back();
        test_random_bursts();
        test_error();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
